// File: rtl/draw_rect_if.sv
// Command and pixel-stream bundle for draw_rect_engine.
// DRAW_RECT_BORDER_COLOUR_EN adds a separate border colour input.
interface draw_rect_if #(
   parameter int unsigned X_WIDTH     = 8,
   parameter int unsigned Y_WIDTH     = 9,
   parameter int unsigned PIXEL_WIDTH = 16
);
   logic                   start;
   logic                   mode;
   logic [X_WIDTH-1:0]     x_origin;
   logic [Y_WIDTH-1:0]     y_origin;
   logic [X_WIDTH-1:0]     width;
   logic [Y_WIDTH-1:0]     height;
   logic [PIXEL_WIDTH-1:0] pixel_data;
`ifdef DRAW_RECT_BORDER_COLOUR_EN
   logic [PIXEL_WIDTH-1:0] border_data;
`endif
   logic                   pixel_ready;
   logic                   pixel_write;
   logic [X_WIDTH-1:0]     pixel_x;
   logic [Y_WIDTH-1:0]     pixel_y;
   logic [PIXEL_WIDTH-1:0] pixel_out;
   logic                   busy;
   logic                   done;

   // Command source and LCD sink side
   modport master (
`ifdef DRAW_RECT_BORDER_COLOUR_EN
      output border_data,
`endif
      output start, mode, x_origin, y_origin, width, height, pixel_data, pixel_ready,
      input  pixel_write, pixel_x, pixel_y, pixel_out, busy, done
   );

   // Engine side
   modport slave (
`ifdef DRAW_RECT_BORDER_COLOUR_EN
      input  border_data,
`endif
      input  start, mode, x_origin, y_origin, width, height, pixel_data, pixel_ready,
      output pixel_write, pixel_x, pixel_y, pixel_out, busy, done
   );
endinterface

// File: rtl/draw_rect_engine.sv
// Rectangle rasteriser (filled or outline) with display clipping and valid/ready pixel output.
// DRAW_RECT_BORDER_COLOUR_EN enables a separate colour for edge pixels.
module draw_rect_engine #(
   parameter int unsigned X_WIDTH        = 8,
   parameter int unsigned Y_WIDTH        = 9,
   parameter int unsigned PIXEL_WIDTH    = 16,
   parameter int unsigned DISPLAY_WIDTH  = 240,
   parameter int unsigned DISPLAY_HEIGHT = 320
) (
   input logic        clock,
   input logic        reset,
   draw_rect_if.slave bus
);

   localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(DISPLAY_WIDTH);
   localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(DISPLAY_HEIGHT);

   typedef enum logic [1:0] {StIdle, StScan, StWrite, StDone} state_t;

   state_t                 state;
   logic                   mode_q;
   logic [X_WIDTH-1:0]     xo_q, w_q, cx_q, cx_next;
   logic [Y_WIDTH-1:0]     yo_q, h_q, cy_q, cy_next;
   logic [PIXEL_WIDTH-1:0] fill_q;
`ifdef DRAW_RECT_BORDER_COLOUR_EN
   logic [PIXEL_WIDTH-1:0] border_q;
`endif

   logic [X_WIDTH:0]       abs_x;
   logic [Y_WIDTH:0]       abs_y;
   logic                   last_x, last_y, last_coord, on_edge, drawable;
   logic [PIXEL_WIDTH-1:0] colour;

   always_comb begin
      // One extra bit so origin+offset past the display edge is clipped rather than wrapped
      abs_x      = {1'b0, xo_q} + {1'b0, cx_q};
      abs_y      = {1'b0, yo_q} + {1'b0, cy_q};
      last_x     = (cx_q == w_q - 1'b1);
      last_y     = (cy_q == h_q - 1'b1);
      last_coord = last_x && last_y;
      on_edge    = (cx_q == '0) || last_x || (cy_q == '0) || last_y;
      drawable   = (abs_x < X_LIMIT) && (abs_y < Y_LIMIT) && (!mode_q || on_edge);
      cx_next    = last_x ? '0 : cx_q + 1'b1;
      cy_next    = last_x ? cy_q + 1'b1 : cy_q;
`ifdef DRAW_RECT_BORDER_COLOUR_EN
      colour     = (mode_q || on_edge) ? border_q : fill_q;
`else
      colour     = fill_q;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= StIdle;
         mode_q          <= 1'b0;
         xo_q            <= '0;
         yo_q            <= '0;
         w_q             <= '0;
         h_q             <= '0;
         cx_q            <= '0;
         cy_q            <= '0;
         fill_q          <= '0;
`ifdef DRAW_RECT_BORDER_COLOUR_EN
         border_q        <= '0;
`endif
         bus.pixel_write <= 1'b0;
         bus.pixel_x     <= '0;
         bus.pixel_y     <= '0;
         bus.pixel_out   <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.start) begin
                  mode_q <= bus.mode;
                  xo_q   <= bus.x_origin;
                  yo_q   <= bus.y_origin;
                  w_q    <= bus.width;
                  h_q    <= bus.height;
                  fill_q <= bus.pixel_data;
`ifdef DRAW_RECT_BORDER_COLOUR_EN
                  border_q <= bus.border_data;
`endif
                  cx_q   <= '0;
                  cy_q   <= '0;
                  if (bus.width == '0 || bus.height == '0) begin
                     state    <= StDone;
                     bus.done <= 1'b1;
                  end else begin
                     state    <= StScan;
                     bus.busy <= 1'b1;
                  end
               end
            end
            StScan: begin
               if (drawable) begin
                  bus.pixel_x     <= abs_x[X_WIDTH-1:0];
                  bus.pixel_y     <= abs_y[Y_WIDTH-1:0];
                  bus.pixel_out   <= colour;
                  bus.pixel_write <= 1'b1;
                  state           <= StWrite;
               end else if (last_coord) begin
                  state    <= StDone;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end else begin
                  cx_q <= cx_next;
                  cy_q <= cy_next;
               end
            end
            StWrite: begin
               if (bus.pixel_ready) begin
                  bus.pixel_write <= 1'b0;
                  if (last_coord) begin
                     state    <= StDone;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     cx_q  <= cx_next;
                     cy_q  <= cy_next;
                     state <= StScan;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/draw_rect_engine.md
Name: draw_rect_engine

Overview:
- Parametrised successor to the single-square drawer.
- Rasterises an axis-aligned rectangle, filled or outline-only, into a stream of pixel writes toward the LCD write block, using a valid/ready handshake.
- Clips every pixel to the display bounds.
- Sits between the command/sequencer logic and the LCD pixel-write interface on the DE1-SoC display path.

Parameters:
- X_WIDTH, 8, bit width of x coordinates and rectangle width.
- Y_WIDTH, 9, bit width of y coordinates and rectangle height.
- PIXEL_WIDTH, 16, bits per pixel colour (RGB565 by default).
- DISPLAY_WIDTH, 240, number of visible columns; valid x is 0..DISPLAY_WIDTH-1.
- DISPLAY_HEIGHT, 320, number of visible rows; valid y is 0..DISPLAY_HEIGHT-1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- mode  input  1  0 = filled rectangle, 1 = outline only.
- x_origin  input  X_WIDTH  left column.
- y_origin  input  Y_WIDTH  top row.
- width  input  X_WIDTH  columns; 0 = empty.
- height  input  Y_WIDTH  rows; 0 = empty.
- pixel_data  input  PIXEL_WIDTH  fill/outline colour.
- pixel_ready  input  1  LCD block can accept a pixel this cycle.
- pixel_write  output  1  pixel valid.
- pixel_x  output  X_WIDTH  pixel column.
- pixel_y  output  Y_WIDTH  pixel row.
- pixel_out  output  PIXEL_WIDTH  pixel colour.
- busy  output  1  command in progress; high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - pixel_write, busy, done, pixel_x, pixel_y, pixel_out all 0.
  - Internal counters cleared.
  - Reset mid-command abandons it immediately; no done pulse.
- Command latch: on start in IDLE, all command inputs are captured and the state goes to SCAN. Inputs may then change freely. start outside IDLE is ignored, not queued.
- Scan counters:
  - Column offset cx runs 0..width-1 and row offset cy runs 0..height-1.
  - Raster order: cx is the inner loop, cy the outer.
  - Absolute coordinates use X_WIDTH+1 / Y_WIDTH+1 bit sums, so origin+offset never wraps.
- Drawable pixel: absolute x < DISPLAY_WIDTH and absolute y < DISPLAY_HEIGHT, and additionally, when mode=1, cx==0, cx==width-1, cy==0 or cy==height-1.
- States:
  - IDLE: busy=0. start with width==0 or height==0 goes to DONE with no writes; otherwise start goes to SCAN.
  - SCAN: evaluates the current (cx, cy), one coordinate per cycle.
    - Drawable: load pixel_x/pixel_y/pixel_out, set pixel_write=1, go to WRITE.
    - Not drawable and last coordinate: go to DONE.
    - Not drawable otherwise: advance counters and stay in SCAN.
  - WRITE: pixel_write and the pixel outputs are held stable until pixel_ready=1 at a clock edge, which is the accept.
    - On accept: pixel_write drops next cycle.
    - If last coordinate, go to DONE; otherwise advance and go to SCAN.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start asserted in that cycle is ignored.
- Latency:
  - First pixel_write rises 2 cycles after the start edge.
  - Minimum 2 cycles per drawn pixel; each skipped coordinate costs 1 cycle.
- Outline special cases: width==1 or height==1 draws every coordinate. Each pixel is written exactly once, including corners.
- A fully off-screen rectangle scans, writes nothing, then pulses done.

Optional Feature:
- Macro: DRAW_RECT_BORDER_COLOUR_EN.
- Defined:
  - Adds input border_data [PIXEL_WIDTH], latched at start.
  - mode=0: edge pixels use border_data and interior pixels use pixel_data.
  - mode=1: all pixels use border_data.
- Undefined: the port is absent and every pixel uses pixel_data.

Test Plan:
- Fill, pixel_ready tied 1: origin (10,20), 3x2, mode 0 -> 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done pulses once; busy high throughout.
- Outline: origin (0,0), 4x4, mode 1 -> 12 writes, interior (1,1),(2,1),(1,2),(2,2) never written.
- Clipping: origin (238,318), 5x5, fill -> exactly 4 writes at (238..239, 318..319); no coordinate wraps to 0.
- Backpressure: pixel_ready low for 7 cycles during the first write -> pixel_write, pixel_x/pixel_y, pixel_out held stable all 7 cycles; the pixel is accepted once when ready rises.
- Zero size and start while busy: width=0 -> done 1 cycle after start with no writes. A start during a 2x2 command -> ignored; exactly 4 writes occur.
- Reset mid-command: reset after the 3rd accept of a 4x4 fill -> all outputs 0 immediately, no done pulse; a new command afterwards runs normally from its own origin.
